// File: rtl/writeback_arbiter_pkg.sv
// Shared decode/issue definitions: register-address width derivation and the
// writeback message carried from execute pipes to the register-file port.
package writeback_arbiter_pkg;

  localparam int unsigned c_num_regs   = 32;
  localparam int unsigned c_entry_bits = 32;

  function automatic int unsigned addr_bits(input int unsigned num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

  localparam int unsigned c_addr_bits = addr_bits(c_num_regs);

  typedef struct packed {
    logic [c_addr_bits-1:0]  waddr;
    logic [c_entry_bits-1:0] wdata;
    logic                    wen;
  } wb_msg_t;

endpackage

// File: rtl/writeback_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or above the
// pointer; the pointer moves past the winner whenever a grant is issued.
module rr_arbiter #(
  parameter int p_width = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [p_width-1:0] req,
  output logic [p_width-1:0] grant
);

  localparam int c_ptr_bits = (p_width > 1) ? $clog2(p_width) : 1;

  logic [c_ptr_bits-1:0] ptr_q;
  logic [c_ptr_bits-1:0] ptr_d;
  logic [c_ptr_bits-1:0] idx;
  logic                  hit;

  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    hit   = 1'b0;
    idx   = '0;
    for (int i = 0; i < p_width; i++) begin
      idx = c_ptr_bits'((int'(ptr_q) + i) % p_width);
      if (en && !hit && req[idx]) begin
        grant[idx] = 1'b1;
        hit        = 1'b1;
        ptr_d      = c_ptr_bits'((int'(ptr_q) + i + 1) % p_width);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: picks one completed execute pipe per cycle round-robin and
// registers its result onto the single register-file write port.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter  int p_num_pipes  = 2,
  parameter  int p_entry_bits = 32,
  parameter  int p_num_regs   = 32,
  localparam int c_aw         = addr_bits(p_num_regs)
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [p_num_pipes-1:0]                   pipe_val,
  output logic [p_num_pipes-1:0]                   pipe_rdy,
  input  logic [p_num_pipes-1:0][c_aw-1:0]         pipe_waddr,
  input  logic [p_num_pipes-1:0][p_entry_bits-1:0] pipe_wdata,
  input  logic [p_num_pipes-1:0]                   pipe_wen,
  output logic [c_aw-1:0]                          waddr,
  output logic [p_entry_bits-1:0]                  wdata,
  output logic                                     wen,
  output logic [31:0]                              retire_count
);

  logic [p_num_pipes-1:0]  grant;
  logic                    xfer;
  logic [c_aw-1:0]         sel_waddr;
  logic [p_entry_bits-1:0] sel_wdata;
  logic                    sel_wen;

  logic [c_aw-1:0]         waddr_q, waddr_d;
  logic [p_entry_bits-1:0] wdata_q, wdata_d;
  logic                    wen_q, wen_d;
  logic [31:0]             retire_count_q, retire_count_d;

  // Grants are suppressed while reset is held so nothing transfers during reset.
  rr_arbiter #(
    .p_width (p_num_pipes)
  ) u_rr_arbiter (
    .clk   (clk),
    .rst   (rst),
    .en    (rst),
    .req   (pipe_val),
    .grant (grant)
  );

  assign pipe_rdy = grant;

  always_comb begin
    xfer      = |grant;
    sel_waddr = '0;
    sel_wdata = '0;
    sel_wen   = 1'b0;
    for (int i = 0; i < p_num_pipes; i++) begin
      if (grant[i]) begin
        sel_waddr = sel_waddr | pipe_waddr[i];
        sel_wdata = sel_wdata | pipe_wdata[i];
        sel_wen   = sel_wen | pipe_wen[i];
      end
    end
  end

  // Writes to x0 and non-writing instructions retire silently; the address and
  // data registers keep their old contents so the port does not toggle.
  always_comb begin
    wen_d          = xfer && sel_wen && (sel_waddr != '0);
    waddr_d        = wen_d ? sel_waddr : waddr_q;
    wdata_d        = wen_d ? sel_wdata : wdata_q;
    retire_count_d = retire_count_q + 32'(xfer);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      waddr_q        <= '0;
      wdata_q        <= '0;
      wen_q          <= 1'b0;
      retire_count_q <= '0;
    end else begin
      waddr_q        <= waddr_d;
      wdata_q        <= wdata_d;
      wen_q          <= wen_d;
      retire_count_q <= retire_count_d;
    end
  end

  assign waddr        = waddr_q;
  assign wdata        = wdata_q;
  assign wen          = wen_q;
  assign retire_count = retire_count_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Testbench for writeback_arbiter: directed vector table on a 2-pipe instance,
// reset corner cases, and a randomized scoreboard run on a 4-pipe instance.
module tb_writeback_arbiter;

  typedef struct {
    logic [1:0]  val;
    logic [1:0]  wen;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  rdy;
    logic        ewen;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic [31:0] ecnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]       p2_val, p2_rdy, p2_wen;
  logic [1:0][4:0]  p2_waddr;
  logic [1:0][31:0] p2_wdata;
  logic [4:0]       o2_waddr;
  logic [31:0]      o2_wdata, o2_cnt;
  logic             o2_wen;

  logic [3:0]       p4_val, p4_rdy, p4_wen;
  logic [3:0][4:0]  p4_waddr;
  logic [3:0][31:0] p4_wdata;
  logic [4:0]       o4_waddr;
  logic [31:0]      o4_wdata, o4_cnt;
  logic             o4_wen;

  int total = 0;
  int bad   = 0;

  writeback_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .pipe_val     (p2_val),
    .pipe_rdy     (p2_rdy),
    .pipe_waddr   (p2_waddr),
    .pipe_wdata   (p2_wdata),
    .pipe_wen     (p2_wen),
    .waddr        (o2_waddr),
    .wdata        (o2_wdata),
    .wen          (o2_wen),
    .retire_count (o2_cnt)
  );

  writeback_arbiter #(.p_num_pipes(4)) dut4 (
    .clk          (clk),
    .rst          (rst),
    .pipe_val     (p4_val),
    .pipe_rdy     (p4_rdy),
    .pipe_waddr   (p4_waddr),
    .pipe_wdata   (p4_wdata),
    .pipe_wen     (p4_wen),
    .waddr        (o4_waddr),
    .wdata        (o4_wdata),
    .wen          (o4_wen),
    .retire_count (o4_cnt)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    p2_val      = v.val;
    p2_wen      = v.wen;
    p2_waddr[0] = v.a0;
    p2_waddr[1] = v.a1;
    p2_wdata[0] = v.d0;
    p2_wdata[1] = v.d1;
  endtask

  vec_t vecs[12];

  int          mptr, g, idx;
  logic [3:0]  exp_rdy;
  logic        m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata, m_cnt;
  int          wait_cnt[4];
  int          max_wait;

  initial begin
    // val wen a0 a1 d0 d1 | rdy ewen ea ed ecnt (outputs after the edge)
    vecs[0]  = '{2'b00, 2'b00, 5'd0,  5'd0, 32'h0,        32'h0,        2'b00, 1'b0, 5'd0,  32'h0,        32'd0};
    vecs[1]  = '{2'b01, 2'b01, 5'd5,  5'd0, 32'hDEADBEEF, 32'h0,        2'b01, 1'b1, 5'd5,  32'hDEADBEEF, 32'd1};
    vecs[2]  = '{2'b11, 2'b11, 5'd3,  5'd4, 32'h11111111, 32'h22222222, 2'b10, 1'b1, 5'd4,  32'h22222222, 32'd2};
    vecs[3]  = '{2'b11, 2'b11, 5'd3,  5'd4, 32'h11111111, 32'h22222222, 2'b01, 1'b1, 5'd3,  32'h11111111, 32'd3};
    vecs[4]  = '{2'b11, 2'b11, 5'd6,  5'd9, 32'h33333333, 32'h44444444, 2'b10, 1'b1, 5'd9,  32'h44444444, 32'd4};
    vecs[5]  = '{2'b11, 2'b11, 5'd6,  5'd9, 32'h33333333, 32'h44444444, 2'b01, 1'b1, 5'd6,  32'h33333333, 32'd5};
    vecs[6]  = '{2'b01, 2'b01, 5'd0,  5'd0, 32'h55555555, 32'h0,        2'b01, 1'b0, 5'd6,  32'h33333333, 32'd6};
    vecs[7]  = '{2'b11, 2'b01, 5'd3,  5'd7, 32'h99999999, 32'h66666666, 2'b10, 1'b0, 5'd6,  32'h33333333, 32'd7};
    vecs[8]  = '{2'b10, 2'b10, 5'd0,  5'd2, 32'h0,        32'h77777777, 2'b10, 1'b1, 5'd2,  32'h77777777, 32'd8};
    vecs[9]  = '{2'b11, 2'b11, 5'd1,  5'd2, 32'h88888888, 32'h77777777, 2'b01, 1'b1, 5'd1,  32'h88888888, 32'd9};
    vecs[10] = '{2'b00, 2'b00, 5'd0,  5'd0, 32'h0,        32'h0,        2'b00, 1'b0, 5'd1,  32'h88888888, 32'd9};
    vecs[11] = '{2'b01, 2'b01, 5'd31, 5'd0, 32'hFFFFFFFF, 32'h0,        2'b01, 1'b1, 5'd31, 32'hFFFFFFFF, 32'd10};

    rst      = 1'b0;
    p2_val   = 2'b11;
    p2_wen   = 2'b11;
    p2_waddr = '0;
    p2_wdata = '0;
    p4_val   = '0;
    p4_wen   = '0;
    p4_waddr = '0;
    p4_wdata = '0;
    #2;
    checkOutput("reset_rdy", 32'(p2_rdy), 32'h0);
    checkOutput("reset_wen", 32'(o2_wen), 32'h0);
    checkOutput("reset_cnt", o2_cnt, 32'h0);
    checkOutput("reset_waddr", 32'(o2_waddr), 32'h0);
    checkOutput("reset_wdata", o2_wdata, 32'h0);
    @(negedge clk);
    p2_val = 2'b00;
    rst    = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d_rdy", i), 32'(p2_rdy), 32'(vecs[i].rdy));
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_wen", i), 32'(o2_wen), 32'(vecs[i].ewen));
      checkOutput($sformatf("vec%0d_waddr", i), 32'(o2_waddr), 32'(vecs[i].ea));
      checkOutput($sformatf("vec%0d_wdata", i), o2_wdata, vecs[i].ed);
      checkOutput($sformatf("vec%0d_cnt", i), o2_cnt, vecs[i].ecnt);
    end

    // Transfer, then drop reset between edges while the write is pending.
    @(negedge clk);
    p2_val      = 2'b11;
    p2_wen      = 2'b11;
    p2_waddr[0] = 5'd8;
    p2_waddr[1] = 5'd9;
    p2_wdata[0] = 32'hAAAA0000;
    p2_wdata[1] = 32'hBBBB0000;
    #1;
    checkOutput("mid_rdy", 32'(p2_rdy), 32'h2);
    @(posedge clk);
    #1;
    checkOutput("mid_wen", 32'(o2_wen), 32'h1);
    checkOutput("mid_waddr", 32'(o2_waddr), 32'd9);
    checkOutput("mid_cnt", o2_cnt, 32'd11);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_wen", 32'(o2_wen), 32'h0);
    checkOutput("async_cnt", o2_cnt, 32'h0);
    checkOutput("async_rdy", 32'(p2_rdy), 32'h0);
    checkOutput("async_waddr", 32'(o2_waddr), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("post_reset_rdy", 32'(p2_rdy), 32'h1);
    @(posedge clk);
    #1;
    checkOutput("post_reset_wen", 32'(o2_wen), 32'h1);
    checkOutput("post_reset_waddr", 32'(o2_waddr), 32'd8);
    checkOutput("post_reset_wdata", o2_wdata, 32'hAAAA0000);
    checkOutput("post_reset_cnt", o2_cnt, 32'd1);
    p2_val = 2'b00;

    // Random stress on the 4-pipe instance; pipes hold their request until granted.
    mptr     = 0;
    m_wen    = 1'b0;
    m_waddr  = '0;
    m_wdata  = '0;
    m_cnt    = '0;
    max_wait = 0;
    for (int p = 0; p < 4; p++) wait_cnt[p] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int p = 0; p < 4; p++) begin
        if (!p4_val[p] && $urandom_range(0, 2) != 0) begin
          p4_val[p]   = 1'b1;
          p4_waddr[p] = 5'($urandom_range(0, 31));
          p4_wdata[p] = $urandom;
          p4_wen[p]   = ($urandom_range(0, 3) != 0);
        end
      end
      g = -1;
      for (int k = 0; k < 4; k++) begin
        idx = (mptr + k) % 4;
        if (g < 0 && p4_val[idx]) g = idx;
      end
      exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      #1;
      checkOutput("stress_rdy", 32'(p4_rdy), 32'(exp_rdy));
      for (int p = 0; p < 4; p++) begin
        if (p4_val[p] && !p4_rdy[p]) wait_cnt[p]++;
        else wait_cnt[p] = 0;
        if (wait_cnt[p] > max_wait) max_wait = wait_cnt[p];
      end
      if (g >= 0) begin
        m_cnt = m_cnt + 1;
        mptr  = (g + 1) % 4;
        if (p4_wen[g] && p4_waddr[g] != 5'd0) begin
          m_wen   = 1'b1;
          m_waddr = p4_waddr[g];
          m_wdata = p4_wdata[g];
        end else begin
          m_wen = 1'b0;
        end
      end else begin
        m_wen = 1'b0;
      end
      @(posedge clk);
      #1;
      checkOutput("stress_wen", 32'(o4_wen), 32'(m_wen));
      checkOutput("stress_waddr", 32'(o4_waddr), 32'(m_waddr));
      checkOutput("stress_wdata", o4_wdata, m_wdata);
      checkOutput("stress_cnt", o4_cnt, m_cnt);
      if (g >= 0) p4_val[g] = 1'b0;
    end
    checkOutput("stress_max_wait_le3", 32'(max_wait <= 3), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
